// File: rtl/fetch_unit_pkg.sv
// Shared constants and IF/ID payload type for the P7 instruction-fetch stage.
package fetch_unit_pkg;

    localparam logic [31:0] PC_RESET_DEF   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;
    localparam logic [31:0] IM_BASE_DEF    = 32'h0000_3000;
    localparam int unsigned IM_AW_DEF      = 12;

    localparam logic [4:0]  EXC_ADEL = 5'd4;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic        bd;
        logic        adel;
    } if_id_t;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall holds every field.
module fetch_unit_if_id_reg
    import fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_flush,
    input  logic        i_stall,
    input  logic [31:0] i_flush_pc,
    input  if_id_t      i_d,
    output if_id_t      o_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q <= '0;
        end else if (i_flush) begin
            o_q.instr <= NOP;
            o_q.pc    <= i_flush_pc;
            o_q.valid <= 1'b0;
            o_q.bd    <= 1'b0;
            o_q.adel  <= 1'b0;
        end else if (!i_stall) begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC selection, IM addressing and IF/ID.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] PC_RESET   = PC_RESET_DEF,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
    parameter logic [31:0] IM_BASE    = IM_BASE_DEF,
    parameter int unsigned IM_AW      = IM_AW_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic [31:0] im_addr,
    input  logic [31:0] im_instr,
    output logic [31:0] if_pc,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        id_valid,
    output logic        id_bd,
    output logic        id_adel
);

    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] w_offset;
    logic        w_addr_err;
    logic        w_flush;
    if_id_t      w_if_d;
    if_id_t      w_if_q;

    // Misaligned or outside the instruction memory window.
    assign w_offset   = r_pc - IM_BASE;
    assign w_addr_err = (r_pc[1:0] != 2'b00) || (r_pc < IM_BASE) ||
                        ((w_offset >> (IM_AW + 2)) != 32'd0);

    assign im_addr = w_addr_err ? 32'd0 : (w_offset >> 2);
    assign if_pc   = r_pc;

    always_comb begin
        w_pc_next = r_pc + 32'd4;
        if (exc_req) begin
            w_pc_next = EXC_VECTOR;
        end else if (eret_req) begin
            w_pc_next = epc;
        end else if (stall) begin
            w_pc_next = r_pc;
        end else if (redirect_valid) begin
            w_pc_next = redirect_target;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= PC_RESET;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    // The instruction fetched alongside an accepted redirect is the delay slot.
    assign w_flush      = exc_req | eret_req;
    assign w_if_d.instr = w_addr_err ? NOP : im_instr;
    assign w_if_d.pc    = r_pc;
    assign w_if_d.valid = 1'b1;
    assign w_if_d.bd    = redirect_valid;
    assign w_if_d.adel  = w_addr_err;

    fetch_unit_if_id_reg u_if_id_reg (
        .clk        (clk),
        .rst_n      (reset),
        .i_flush    (w_flush),
        .i_stall    (stall),
        .i_flush_pc (r_pc),
        .i_d        (w_if_d),
        .o_q        (w_if_q)
    );

    assign id_instr = w_if_q.instr;
    assign id_pc    = w_if_q.pc;
    assign id_valid = w_if_q.valid;
    assign id_bd    = w_if_q.bd;
    assign id_adel  = w_if_q.adel;

endmodule
